// File: rtl/video_start_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : video_start_sequencer
// Description : Sequences the HDMI video generator through power-up, PLL lock
//               changes and video-mode reconfiguration. Holds the generator
//               in reset, waits for the capture side to start a frame and
//               buffer START_LINES lines, then fires a one-cycle start pulse.
//               A config update or loss of lock forces a full resync.
//
// Ports       : clock              output pixel clock
//               reset              asynchronous, active-high reset
//               i_pll_locked       output PLL lock (synchronous to clock)
//               i_cfg_update       pulse: new video config latched
//               i_wr_frame_start   pulse: first line of a frame written
//               i_wr_line_done     pulse: one buffered line completed
//               i_fullcycle        generator finished its sync warm-up
//               o_gen_reset        reset to the video generator
//               o_starttrigger     one-cycle start pulse to the generator
//               o_running          high while in RUN
//               o_resync_count     saturating count of counted resyncs
//
// Options     : SEQ_WATCHDOG_EN - when defined, a watchdog forces a counted
//               resync if i_fullcycle does not rise within WATCHDOG_CYCLES of
//               entering RUN. When undefined, i_fullcycle is ignored.
//
// Revision    : 1.0 - initial release
// ============================================================================
module video_start_sequencer #(
    parameter int unsigned RESET_CYCLES    = 16,
    parameter int unsigned START_LINES     = 4,
    parameter int unsigned WATCHDOG_CYCLES = 2000000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       i_pll_locked,
    input  logic       i_cfg_update,
    input  logic       i_wr_frame_start,
    input  logic       i_wr_line_done,
    input  logic       i_fullcycle,
    output logic       o_gen_reset,
    output logic       o_starttrigger,
    output logic       o_running,
    output logic [7:0] o_resync_count
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_HOLD = 3'd1,
        S_ARM  = 3'd2,
        S_FILL = 3'd3,
        S_TRIG = 3'd4,
        S_RUN  = 3'd5
    } state_t;

    localparam logic [7:0] c_HOLD_LOAD   = 8'(RESET_CYCLES - 1);
    localparam logic [7:0] c_START_LINES = 8'(START_LINES);

    state_t     r_state;
    logic [7:0] r_hold_cnt;
    logic [7:0] r_line_cnt;
    logic [7:0] r_resync_cnt;
    logic       r_gen_reset;
    logic       r_starttrigger;
    logic       r_running;

    state_t     w_state_next;
    logic [7:0] w_hold_next;
    logic [7:0] w_line_next;
    logic [7:0] w_restart_count;
    logic [7:0] w_fill_count;
    logic       w_resync;
    logic       w_resync_counted;
    logic       w_wd_trip;

`ifdef SEQ_WATCHDOG_EN
    localparam logic [23:0] c_WD_LIMIT = 24'(WATCHDOG_CYCLES);

    logic [23:0] r_wd_cnt;
    logic        r_fc_seen;
    logic [23:0] w_wd_inc;

    assign w_wd_inc  = r_wd_cnt + 24'd1;
    // Trip on the cycle the count would reach the limit, so the resync is
    // visible exactly WATCHDOG_CYCLES cycles after RUN is entered.
    assign w_wd_trip = (r_state == S_RUN) && !r_fc_seen && !i_fullcycle
                       && (w_wd_inc == c_WD_LIMIT);
`else
    localparam int unsigned c_unused_wd_cycles = WATCHDOG_CYCLES;
    logic w_unused_fullcycle;

    assign w_unused_fullcycle = i_fullcycle;
    assign w_wd_trip          = 1'b0;
`endif

    // A frame start restarts the line count; a coincident line counts as 1.
    assign w_restart_count = {7'd0, i_wr_line_done};
    assign w_fill_count    = i_wr_line_done ? (r_line_cnt + 8'd1) : r_line_cnt;

    assign w_resync = (r_state != S_IDLE)
                      && (!i_pll_locked || i_cfg_update || w_wd_trip);
    assign w_resync_counted = w_resync && (r_state != S_HOLD);

    always_comb begin
        w_state_next = r_state;
        w_hold_next  = r_hold_cnt;
        w_line_next  = r_line_cnt;

        case (r_state)
            S_IDLE: begin
                if (i_pll_locked) begin
                    w_state_next = S_HOLD;
                    w_hold_next  = c_HOLD_LOAD;
                end
            end
            S_HOLD: begin
                if (r_hold_cnt == 8'd0) begin
                    w_state_next = S_ARM;
                end else begin
                    w_hold_next = r_hold_cnt - 8'd1;
                end
            end
            S_ARM: begin
                if (i_wr_frame_start) begin
                    w_line_next  = w_restart_count;
                    w_state_next = (w_restart_count == c_START_LINES) ? S_TRIG : S_FILL;
                end
            end
            S_FILL: begin
                w_line_next = i_wr_frame_start ? w_restart_count : w_fill_count;
                if (w_line_next == c_START_LINES) begin
                    w_state_next = S_TRIG;
                end
            end
            S_TRIG: begin
                w_state_next = S_RUN;
            end
            S_RUN: begin
                w_state_next = S_RUN;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase

        // Resync wins over every ordinary transition.
        if (w_resync) begin
            if (!i_pll_locked) begin
                w_state_next = S_IDLE;
            end else begin
                w_state_next = S_HOLD;
                w_hold_next  = c_HOLD_LOAD;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state        <= S_IDLE;
            r_hold_cnt     <= 8'd0;
            r_line_cnt     <= 8'd0;
            r_resync_cnt   <= 8'd0;
            r_gen_reset    <= 1'b1;
            r_starttrigger <= 1'b0;
            r_running      <= 1'b0;
`ifdef SEQ_WATCHDOG_EN
            r_wd_cnt       <= 24'd0;
            r_fc_seen      <= 1'b0;
`endif
        end else begin
            r_state    <= w_state_next;
            r_hold_cnt <= w_hold_next;
            r_line_cnt <= w_line_next;

            if (w_resync_counted && (r_resync_cnt != 8'hFF)) begin
                r_resync_cnt <= r_resync_cnt + 8'd1;
            end

            // Outputs decode the next state so they line up with r_state.
            r_gen_reset    <= (w_state_next == S_IDLE) || (w_state_next == S_HOLD);
            r_starttrigger <= (w_state_next == S_TRIG);
            r_running      <= (w_state_next == S_RUN);

`ifdef SEQ_WATCHDOG_EN
            if (r_state == S_TRIG) begin
                r_wd_cnt  <= 24'd0;
                r_fc_seen <= 1'b0;
            end else if (r_state == S_RUN) begin
                if (i_fullcycle) begin
                    r_fc_seen <= 1'b1;
                end else if (!r_fc_seen) begin
                    r_wd_cnt <= w_wd_inc;
                end
            end
`endif
        end
    end

    assign o_gen_reset    = r_gen_reset;
    assign o_starttrigger = r_starttrigger;
    assign o_running      = r_running;
    assign o_resync_count = r_resync_cnt;

endmodule
`default_nettype wire

// File: tb/tb_video_start_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_video_start_sequencer
// Description : Directed self-checking bench for video_start_sequencer with
//               RESET_CYCLES=16, START_LINES=4, WATCHDOG_CYCLES=100. Inputs
//               change 1 time unit after the rising edge and outputs are
//               checked there. Honours SEQ_WATCHDOG_EN like the design.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_video_start_sequencer;

    logic       clock = 1'b0;
    logic       reset;
    logic       i_pll_locked;
    logic       i_cfg_update;
    logic       i_wr_frame_start;
    logic       i_wr_line_done;
    logic       i_fullcycle;
    logic       o_gen_reset;
    logic       o_starttrigger;
    logic       o_running;
    logic [7:0] o_resync_count;

    int n_checks = 0;
    int n_fail   = 0;

    video_start_sequencer #(
        .RESET_CYCLES    (16),
        .START_LINES     (4),
        .WATCHDOG_CYCLES (100)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .i_pll_locked     (i_pll_locked),
        .i_cfg_update     (i_cfg_update),
        .i_wr_frame_start (i_wr_frame_start),
        .i_wr_line_done   (i_wr_line_done),
        .i_fullcycle      (i_fullcycle),
        .o_gen_reset      (o_gen_reset),
        .o_starttrigger   (o_starttrigger),
        .o_running        (o_running),
        .o_resync_count   (o_resync_count)
    );

    always #5 clock = ~clock;

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Checks the three 1-bit outputs at once: {gen_reset, starttrigger, running}.
    task automatic chk_out(input string tag, input logic [2:0] exp);
        chk(tag, {29'd0, o_gen_reset, o_starttrigger, o_running}, {29'd0, exp});
    endtask

    initial begin
        reset            = 1'b1;
        i_pll_locked     = 1'b0;
        i_cfg_update     = 1'b0;
        i_wr_frame_start = 1'b0;
        i_wr_line_done   = 1'b0;
        i_fullcycle      = 1'b0;
        tick(3);
        chk_out("reset_outputs", 3'b100);
        chk("reset_resync", {24'd0, o_resync_count}, 32'd0);

        // Power-up: idle without lock, then lock -> 16 cycles of gen_reset.
        reset = 1'b0;
        tick(4);
        chk_out("idle_no_lock", 3'b100);
        i_pll_locked = 1'b1;
        tick(16);
        chk_out("hold_last_cycle", 3'b100);
        tick(1);
        chk_out("arm_after_hold", 3'b000);

        // Frame start + 4 lines -> one trigger, then running.
        i_wr_frame_start = 1'b1; tick(1); i_wr_frame_start = 1'b0;
        i_wr_line_done = 1'b1;
        tick(3);
        chk_out("fill_3_lines", 3'b000);
        tick(1);
        i_wr_line_done = 1'b0;
        chk_out("trigger_pulse", 3'b010);
        tick(1);
        chk_out("run_entry", 3'b001);
        tick(5);
        chk_out("run_stays", 3'b001);

        // Config change in RUN.
        i_cfg_update = 1'b1; tick(1); i_cfg_update = 1'b0;
        chk_out("cfg_resync", 3'b100);
        chk("cfg_resync_count", {24'd0, o_resync_count}, 32'd1);
        tick(15);
        chk_out("cfg_hold_last", 3'b100);
        tick(1);
        chk_out("cfg_arm", 3'b000);

        // FILL restart: 2 lines, new frame start, then 4 more lines needed.
        i_wr_frame_start = 1'b1; tick(1); i_wr_frame_start = 1'b0;
        i_wr_line_done = 1'b1; tick(2); i_wr_line_done = 1'b0;
        i_wr_frame_start = 1'b1; tick(1); i_wr_frame_start = 1'b0;
        i_wr_line_done = 1'b1;
        tick(3);
        chk_out("restart_3_lines", 3'b000);
        tick(1);
        i_wr_line_done = 1'b0;
        chk_out("restart_trigger", 3'b010);
        chk("restart_resync_count", {24'd0, o_resync_count}, 32'd1);
        tick(1);
        chk_out("restart_run", 3'b001);

        // cfg_update coincident with the 4th line: no trigger, back to HOLD.
        i_cfg_update = 1'b1; tick(1); i_cfg_update = 1'b0;   // RUN -> HOLD, count 2
        tick(16);
        chk_out("sim_arm", 3'b000);
        i_wr_frame_start = 1'b1; i_wr_line_done = 1'b1;
        tick(1);
        i_wr_frame_start = 1'b0;
        tick(2);
        chk_out("sim_3_lines", 3'b000);
        i_cfg_update = 1'b1;
        tick(1);
        i_cfg_update = 1'b0; i_wr_line_done = 1'b0;
        chk_out("sim_cfg_wins", 3'b100);
        chk("sim_resync_count", {24'd0, o_resync_count}, 32'd3);

        // Lock loss during HOLD: IDLE, count unchanged, full hold on return.
        tick(5);
        i_pll_locked = 1'b0;
        tick(1);
        chk("hold_loss_count", {24'd0, o_resync_count}, 32'd3);
        tick(20);
        chk_out("hold_loss_idle", 3'b100);
        i_pll_locked = 1'b1;
        tick(16);
        chk_out("relock_hold_last", 3'b100);
        tick(1);
        chk_out("relock_arm", 3'b000);

        // Lock loss during FILL: IDLE, count incremented, no trigger.
        i_wr_frame_start = 1'b1; tick(1); i_wr_frame_start = 1'b0;
        i_wr_line_done = 1'b1; tick(2); i_wr_line_done = 1'b0;
        i_pll_locked = 1'b0;
        tick(1);
        chk_out("fill_loss_idle", 3'b100);
        chk("fill_loss_count", {24'd0, o_resync_count}, 32'd4);
        tick(3);
        i_pll_locked = 1'b1;
        tick(16);
        chk_out("fill_relock_hold", 3'b100);
        tick(1);
        chk_out("fill_relock_arm", 3'b000);

        // Line done coincident with frame start in ARM counts as line 1.
        i_wr_frame_start = 1'b1; i_wr_line_done = 1'b1;
        tick(1);
        i_wr_frame_start = 1'b0;
        tick(2);
        chk_out("coinc_3_lines", 3'b000);
        tick(1);
        i_wr_line_done = 1'b0;
        chk_out("coinc_trigger", 3'b010);
        tick(1);
        chk_out("coinc_run", 3'b001);

`ifdef SEQ_WATCHDOG_EN
        // Watchdog: fullcycle held low -> resync 100 cycles after RUN entry.
        tick(99);
        chk_out("wd_before_trip", 3'b001);
        tick(1);
        chk_out("wd_trip", 3'b100);
        chk("wd_trip_count", {24'd0, o_resync_count}, 32'd5);
        tick(15);
        chk_out("wd_hold_last", 3'b100);
        tick(1);
        i_wr_frame_start = 1'b1; tick(1); i_wr_frame_start = 1'b0;
        i_wr_line_done = 1'b1; tick(4); i_wr_line_done = 1'b0;
        chk_out("wd_retrigger", 3'b010);
        tick(1);
        chk_out("wd_rerun", 3'b001);
        // fullcycle seen at cycle 50 freezes the watchdog.
        tick(49);
        i_fullcycle = 1'b1; tick(1); i_fullcycle = 1'b0;
        tick(200);
        chk_out("wd_frozen_run", 3'b001);
        chk("wd_frozen_count", {24'd0, o_resync_count}, 32'd5);
`else
        // No watchdog: RUN persists with fullcycle low.
        tick(150);
        chk_out("nowd_run_persists", 3'b001);
        chk("nowd_count", {24'd0, o_resync_count}, 32'd4);
`endif

        // 300 forced resyncs -> count saturates at 255.
        for (int i = 0; i < 300; i++) begin
            i_cfg_update = 1'b1; tick(1); i_cfg_update = 1'b0;
            tick(16);
        end
        chk("saturate_count", {24'd0, o_resync_count}, 32'd255);
        chk_out("saturate_arm", 3'b000);

        // Asynchronous reset mid-operation clears outputs without a clock edge.
        #2;
        reset = 1'b1;
        #1;
        chk_out("async_reset_outputs", 3'b100);
        chk("async_reset_count", {24'd0, o_resync_count}, 32'd0);
        tick(2);
        reset = 1'b0;
        tick(1);
        chk_out("release_no_pulse", 3'b100);
        tick(16);
        chk_out("release_rearm", 3'b000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
